// File: rtl/seq_add_pkg.sv
// Shared definitions for the sequential 64-bit adder/subtractor:
// slice geometry and the controller state encoding.
package seq_add_pkg;

    // Width of the single time-shared adder slice.
    localparam int CHUNK_W    = 16;
    // Number of slices per operand; operand width is CHUNK_W * NUM_CHUNKS.
    localparam int NUM_CHUNKS = 4;
    localparam int DATA_W     = CHUNK_W * NUM_CHUNKS;

    // Controller states. IDLE waits for an operation, RUN walks the slices
    // (one per cycle), DONE presents the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_add_pkg

// File: rtl/add_chunk16.sv
// Combinational CHUNK_W-bit adder slice. Besides the carry out of the MSB it
// exposes the carry into the MSB, which the top level needs to derive
// two's-complement overflow on the last slice.
module add_chunk16
    import seq_add_pkg::*;
#(
    parameter int CHUNK_W = seq_add_pkg::CHUNK_W
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic [CHUNK_W-1:0] low;
    logic [1:0]         top;

    // Add the low CHUNK_W-1 bits first so the carry into the MSB is visible,
    // then finish the MSB with that carry.
    always_comb begin
        low   = {1'b0, a[CHUNK_W-2:0]} + {1'b0, b[CHUNK_W-2:0]}
              + {{(CHUNK_W-1){1'b0}}, cin};
        top   = {1'b0, a[CHUNK_W-1]} + {1'b0, b[CHUNK_W-1]} + {1'b0, low[CHUNK_W-1]};
        sum   = {top[0], low[CHUNK_W-2:0]};
        cout  = top[1];
        c_msb = low[CHUNK_W-1];
    end

endmodule : add_chunk16

// File: rtl/seq_add64.sv
// Sequential adder/subtractor: one CHUNK_W-bit adder is reused over
// NUM_CHUNKS cycles, carry rippling between slices through a register.
//
// Handshake: both ports use valid/ready. A transfer happens on a rising edge
// where valid and ready are both 1. in_ready is high only in IDLE (and out
// of reset); out_valid is high only in DONE, and sum/cout/ovf are stable for
// as long as out_valid is high and out_ready is low.
module seq_add64
    import seq_add_pkg::*;
#(
    parameter int CHUNK_W    = seq_add_pkg::CHUNK_W,
    parameter int NUM_CHUNKS = seq_add_pkg::NUM_CHUNKS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] a,
    input  logic [CHUNK_W*NUM_CHUNKS-1:0] b,
    input  logic                          cin,
    input  logic                          sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] sum,
    output logic                          cout,
    output logic                          ovf,
    output state_e                        dbg_state
);

    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_e             state_q;
    state_e             state_d;
    logic               accept;
    logic               last_slice;

    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [CHUNK_W-1:0] a_q   [NUM_CHUNKS];
    logic [CHUNK_W-1:0] b_q   [NUM_CHUNKS];
    logic [CHUNK_W-1:0] sum_q [NUM_CHUNKS];
    logic               cout_q;
    logic               ovf_q;

    logic [CHUNK_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;

    // The only adder in the design; the operand slices are selected by idx.
    add_chunk16 #(
        .CHUNK_W (CHUNK_W)
    ) u_add (
        .a     (a_q[idx_q]),
        .b     (b_q[idx_q]),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the accept/last-slice strobes.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_slice = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    last_slice = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture. Subtraction is folded in here: b is inverted once and
    // the initial carry is cin^sub, so the slice loop only ever adds.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                a_q[i] <= a[i*CHUNK_W +: CHUNK_W];
                b_q[i] <= b[i*CHUNK_W +: CHUNK_W] ^ {CHUNK_W{sub}};
            end
        end
    end

    // Slice walk: one slice per RUN cycle, carry held between slices; flags
    // are only written from the last slice so they keep the old result
    // until then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                sum_q[i] <= '0;
            end
        end else if (accept) begin
            idx_q   <= '0;
            carry_q <= cin ^ sub;
        end else if (state_q == RUN) begin
            sum_q[idx_q] <= slice_sum;
            carry_q      <= slice_cout;
            if (last_slice) begin
                cout_q <= slice_cout;
                ovf_q  <= slice_cmsb ^ slice_cout;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // Reassemble the result word from the slice registers.
    for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_sum
        assign sum[g*CHUNK_W +: CHUNK_W] = sum_q[g];
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule : seq_add64

// File: doc/seq_add64.md
SEQ_ADD64 -- requirements
Module: seq_add64

Interface
REQ-001 The block SHALL have parameter CHUNK_W, default 16, meaning the width of the shared adder slice.
REQ-002 The block SHALL have parameter NUM_CHUNKS, default 4, meaning slices per operand (operand width = CHUNK_W*NUM_CHUNKS = 64).
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands and mode are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts a new operation.
REQ-008 The block SHALL have ports a and b, input, 64 bits each: operands.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in for add, or borrow-in for subtract.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 = a+b+cin; 1 = a-b-cin.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 The block SHALL have port sum, output, 64 bits: result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of bit 63; for subtract, 1 = no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE with rst_n=1; out_valid SHALL be 1 only in DONE.
REQ-018 Accept SHALL occur when in_valid & in_ready; on accept the block SHALL latch a, b^{64{sub}}, and carry = cin^sub, clear chunk index to 0, and go to RUN.
REQ-019 In RUN, each cycle SHALL compute one CHUNK_W slice through a single shared adder: sum[idx] = a[idx] + b'[idx] + carry; the carry register and the sum slice SHALL update, and idx SHALL increment.
REQ-020 Carry SHALL propagate only through the carry register between slices; no slice SHALL be computed twice.
REQ-021 After slice NUM_CHUNKS-1 is computed, the FSM SHALL go to DONE; cout SHALL equal the final carry, and ovf SHALL equal the carry into bit 63 XOR the carry out of bit 63.
REQ-022 Latency SHALL be: accept at edge 0, slices at edges 1-4, out_valid=1 from the cycle after edge 4 (5 cycles accept-to-valid).
REQ-023 In DONE, sum, cout and ovf SHALL hold stable until out_valid & out_ready; then the FSM SHALL go to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; a new accept is possible in the cycle after the output handshake (throughput 1 op per 6 cycles with out_ready held at 1).
REQ-025 sum, cout and ovf SHALL keep the last result in IDLE until the next accept overwrites sum slice by slice.
REQ-026 The chunk index SHALL wrap/clear only on accept; it SHALL never exceed NUM_CHUNKS-1 in RUN.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL set state to IDLE, idx to 0, carry to 0, sum to 0, cout to 0, ovf to 0 and out_valid to 0, and hold in_ready at 0.
REQ-028 A reset asserted in RUN or DONE SHALL abort the operation with no partial result or out_valid pulse; after release, in_ready SHALL be 1 in the next cycle.

Structure
REQ-029 The shared package seq_add_pkg SHALL hold the state encoding (IDLE/RUN/DONE), CHUNK_W and NUM_CHUNKS.
REQ-030 The block SHALL use one sub-module, add_chunk16: a combinational CHUNK_W-bit adder with cin, cout and carry-into-MSB outputs, instantiated once and time-shared.

Verification
REQ-031 The bench SHALL check: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=0, cout=1, ovf=0, with out_valid exactly 5 cycles after accept.
REQ-032 The bench SHALL check: a=0x0000_0000_FFFF_FFFF, b=1 -> sum=0x0000_0001_0000_0000, cout=0 (carry crossing a slice boundary).
REQ-033 The bench SHALL check: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0; also a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-034 The bench SHALL check: with out_ready=0 for 3 cycles in DONE, sum, cout and out_valid stay stable, in_ready=0, and an in_valid pulse is ignored; the handshake then completes and the FSM returns to IDLE.
REQ-035 The bench SHALL check: rst_n=0 for one cycle during RUN slice 2 -> next cycle out_valid=0, sum=0, state IDLE, and in_ready=1 after release; no result is emitted.
REQ-036 The bench SHALL check: two back-to-back operations with out_ready=1 -> the second accept occurs the cycle after the first output handshake, and both results are correct.
